// File: rtl/cpu_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_ctrl_pkg
// Brief    : Shared types and default parameters for the CPU run controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

  // Controller phases; explicit 3-bit encoding keeps the register width fixed.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5
  } run_state_t;

  localparam int CPU_CNT_W       = 16;
  localparam int CPU_TIMEOUT     = 1000;
  localparam int CPU_INIT_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/cpu_run_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : cpu_run_ctrl_if
// Brief    : Host/CPU-facing signal bundle of the run controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cpu_run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             mode_step;
  logic             step;
  logic             halt;
  logic             cpu_init;
  logic             cpu_en;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycles;

  // Host / CPU side: issues commands and the decoder halt, observes status.
  modport master (
    output start, stop, mode_step, step, halt,
    input  cpu_init, cpu_en, busy, done, timeout, cycles
  );

  // Controller side.
  modport slave (
    input  start, stop, mode_step, step, halt,
    output cpu_init, cpu_en, busy, done, timeout, cycles
  );
endinterface

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
//------------------------------------------------------------------------------
// Module   : cpu_run_ctrl
// Brief    : Sequences the CPU core: reset hold, free run, single step,
//            stop on halt / abort / cycle-budget timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W       = CPU_CNT_W,
  parameter int INIT_CYCLES = CPU_INIT_CYCLES,
  parameter int TIMEOUT     = CPU_TIMEOUT
) (
  input  wire logic          CLK,
  input  wire logic          init_n,
  cpu_run_ctrl_if.slave      bus
);

  localparam int                IW        = $clog2(INIT_CYCLES + 1);
  localparam logic [IW-1:0]     INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(TIMEOUT - 1);

  run_state_t       state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             timeout_q, timeout_d;
  logic [IW-1:0]    init_cnt_q, init_cnt_d;
  logic             step_q, step_d;
  logic             step_rise;

  // A held step button must only yield one instruction, so PAUSE reacts to
  // the rising edge of step rather than its level.
  assign step_rise = bus.step & ~step_q;

  // Next-state logic. Every RUN/STEP cycle commits an instruction and is
  // counted, including the cycle that leaves on stop, halt or timeout.
  always_comb begin
    state_d    = state_q;
    cycles_d   = cycles_q;
    timeout_d  = timeout_q;
    init_cnt_d = init_cnt_q;
    step_d     = bus.step;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_RESET;
          cycles_d   = '0;
          timeout_d  = 1'b0;
          init_cnt_d = '0;
        end
      end
      S_RESET: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
          if (init_cnt_q == INIT_LAST) begin
            state_d = bus.mode_step ? S_PAUSE : S_RUN;
          end
        end
      end
      S_RUN, S_STEP: begin
        cycles_d = cycles_q + CNT_W'(1);
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.halt) begin
          state_d = S_DONE;
        end else if (cycles_q == CYC_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (state_q == S_STEP) begin
          state_d = S_PAUSE;
        end else if (bus.mode_step) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (step_rise) begin
          state_d = S_STEP;
        end else if (!bus.mode_step) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.start) begin
          state_d    = S_RESET;
          cycles_d   = '0;
          timeout_d  = 1'b0;
          init_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; init_n parks the CPU immediately, even mid-run.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state_q    <= S_IDLE;
      cycles_q   <= '0;
      timeout_q  <= 1'b0;
      init_cnt_q <= '0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycles_q   <= cycles_d;
      timeout_q  <= timeout_d;
      init_cnt_q <= init_cnt_d;
      step_q     <= step_d;
    end
  end

  // Moore output decode from the state register.
  always_comb begin
    bus.cpu_init = (state_q == S_IDLE) || (state_q == S_RESET);
    bus.cpu_en   = (state_q == S_RESET) || (state_q == S_RUN) || (state_q == S_STEP);
    bus.busy     = (state_q == S_RESET) || (state_q == S_RUN) ||
                   (state_q == S_PAUSE) || (state_q == S_STEP);
    bus.done     = (state_q == S_DONE);
    bus.timeout  = timeout_q;
    bus.cycles   = cycles_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_cpu_run_ctrl
// Brief    : Self-checking bench for cpu_run_ctrl (vector table, directed
//            corner sequences, randomized run against a reference model).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_run_ctrl;

  localparam int INIT = 2;
  localparam int TO_A = 50;
  localparam int TO_B = 20;

  // Reference-model phases (bench-local numbering).
  localparam int P_IDLE = 0, P_RESET = 1, P_RUN = 2, P_PAUSE = 3, P_STEP = 4, P_DONE = 5;

  logic CLK = 1'b0;
  logic init_n;
  logic t_start, t_stop, t_mode, t_step, t_halt;

  cpu_run_ctrl_if #(.CNT_W(16)) ifa ();
  cpu_run_ctrl_if #(.CNT_W(16)) ifb ();

  assign ifa.start = t_start;  assign ifb.start = t_start;
  assign ifa.stop  = t_stop;   assign ifb.stop  = t_stop;
  assign ifa.mode_step = t_mode; assign ifb.mode_step = t_mode;
  assign ifa.step  = t_step;   assign ifb.step  = t_step;
  assign ifa.halt  = t_halt;   assign ifb.halt  = t_halt;

  cpu_run_ctrl #(.CNT_W(16), .INIT_CYCLES(INIT), .TIMEOUT(TO_A)) dut_a (
    .CLK(CLK), .init_n(init_n), .bus(ifa));
  cpu_run_ctrl #(.CNT_W(16), .INIT_CYCLES(INIT), .TIMEOUT(TO_B)) dut_b (
    .CLK(CLK), .init_n(init_n), .bus(ifb));

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int m_ph, m_left, m_cyc, m_to, m_prev;

  typedef struct {
    logic st, sp, md, stp, hlt;
    logic ei, ee, eb, ed, et;
    logic [15:0] ec;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [31:0] pk(logic i, logic e, logic b, logic d, logic t, logic [15:0] c);
    return {11'd0, i, e, b, d, t, c};
  endfunction

  function automatic logic [31:0] dut_a_out();
    return pk(ifa.cpu_init, ifa.cpu_en, ifa.busy, ifa.done, ifa.timeout, ifa.cycles);
  endfunction

  function automatic vec_t mk(logic st, logic sp, logic md, logic stp, logic hlt,
                              logic ei, logic ee, logic eb, logic ed, logic et, int ec);
    vec_t v;
    v.st = st; v.sp = sp; v.md = md; v.stp = stp; v.hlt = hlt;
    v.ei = ei; v.ee = ee; v.eb = eb; v.ed = ed; v.et = et; v.ec = 16'(ec);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ph = P_IDLE; m_left = 0; m_cyc = 0; m_to = 0; m_prev = 0;
  endfunction

  // One clock of the rule-level model: executing phases retire one
  // instruction, then exits are tried in priority order.
  function automatic void model_clock();
    case (m_ph)
      P_IDLE: if (t_start) begin m_ph = P_RESET; m_left = INIT; m_cyc = 0; m_to = 0; end
      P_RESET: begin
        m_left = m_left - 1;
        if (t_stop) m_ph = P_IDLE;
        else if (m_left == 0) m_ph = t_mode ? P_PAUSE : P_RUN;
      end
      P_RUN, P_STEP: begin
        m_cyc = m_cyc + 1;
        if (t_stop) m_ph = P_IDLE;
        else if (t_halt) m_ph = P_DONE;
        else if (m_cyc == TO_A) begin m_ph = P_DONE; m_to = 1; end
        else if (m_ph == P_STEP || t_mode) m_ph = P_PAUSE;
      end
      P_PAUSE: begin
        if (t_stop) m_ph = P_IDLE;
        else if (t_step && !m_prev) m_ph = P_STEP;
        else if (!t_mode) m_ph = P_RUN;
      end
      default: begin
        if (t_stop) m_ph = P_IDLE;
        else if (t_start) begin m_ph = P_RESET; m_left = INIT; m_cyc = 0; m_to = 0; end
      end
    endcase
    m_prev = t_step;
  endfunction

  function automatic logic [31:0] model_out();
    return pk(m_ph == P_IDLE || m_ph == P_RESET,
              m_ph == P_RESET || m_ph == P_RUN || m_ph == P_STEP,
              m_ph == P_RESET || m_ph == P_RUN || m_ph == P_PAUSE || m_ph == P_STEP,
              m_ph == P_DONE, m_to[0], 16'(m_cyc));
  endfunction

  task automatic clr_in();
    t_start = 0; t_stop = 0; t_step = 0; t_halt = 0;
  endtask

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic tick();
    model_clock();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    t_mode = 0;
    init_n = 0;
    @(posedge CLK);
    #1;
    model_reset();
    init_n = 1;
  endtask

  initial begin
    int n, en_cnt, init_cnt;
    bit hit;
    clr_in();
    t_mode = 0;
    init_n = 0;
    model_reset();
    @(posedge CLK); #1;
    chk("reset_state", dut_a_out(), pk(1, 0, 0, 0, 0, 0));
    init_n = 1;

    // ---------------- table-driven vectors ----------------
    //           st sp md stp h   ei ee eb ed et cyc
    tbl[0]  = mk(1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 2);
    tbl[5]  = mk(1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 0, 0,  1, 1, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 1, 0,  0, 1, 1, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1, 0,  0, 0, 1, 0, 0, 1);
    tbl[10] = mk(0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 1);
    tbl[11] = mk(0, 0, 1, 1, 0,  0, 1, 1, 0, 0, 1);
    tbl[12] = mk(0, 0, 1, 0, 1,  0, 0, 0, 1, 0, 2);
    tbl[13] = mk(0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 2);
    for (int i = 0; i < 14; i++) begin
      t_start = tbl[i].st; t_stop = tbl[i].sp; t_mode = tbl[i].md;
      t_step = tbl[i].stp; t_halt = tbl[i].hlt;
      tick();
      chk($sformatf("table[%0d]", i), dut_a_out(),
          pk(tbl[i].ei, tbl[i].ee, tbl[i].eb, tbl[i].ed, tbl[i].et, tbl[i].ec));
    end

    // ---------------- reset mid-run ----------------
    do_reset();
    t_start = 1; tick(); t_start = 0;
    n = 0;
    while (ifa.cycles != 16'd37 && n < 100) begin tick(); n++; end
    chk("midrun_cycles", 32'(ifa.cycles), 37);
    #2 init_n = 0;
    #1 chk("midrun_async_reset", dut_a_out(), pk(1, 0, 0, 0, 0, 0));
    @(posedge CLK); #1;
    model_reset();
    init_n = 1;
    t_start = 1; tick(); t_start = 0;
    chk("midrun_rearm", dut_a_out(), pk(1, 1, 1, 0, 0, 0));

    // ---------------- free run, halt on 10th cycle ----------------
    do_reset();
    t_start = 1; tick(); t_start = 0;
    init_cnt = 0; hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (ifa.cpu_init) init_cnt++;
      if (!ifa.cpu_init && ifa.cpu_en && ifa.cycles == 16'd9) begin
        t_halt = 1; tick(); t_halt = 0; hit = 1;
      end else begin
        tick();
      end
    end
    chk("halt_reached", 32'(hit), 1);
    chk("halt_init_cycles", 32'(init_cnt), 2);
    chk("halt_result", dut_a_out(), pk(0, 0, 0, 1, 0, 10));

    // ---------------- priority: start ignored, stop beats halt ----------------
    do_reset();
    t_start = 1; tick(); t_start = 0;
    n = 0;
    while (ifa.cycles != 16'd5 && n < 100) begin tick(); n++; end
    t_start = 1; tick(); t_start = 0;
    chk("start_while_busy", dut_a_out(), pk(0, 1, 1, 0, 0, 6));
    t_stop = 1; t_halt = 1; tick(); t_stop = 0; t_halt = 0;
    chk("stop_beats_halt", dut_a_out(), pk(1, 0, 0, 0, 0, 7));

    // ---------------- single step ----------------
    do_reset();
    t_mode = 1;
    t_start = 1; tick(); t_start = 0;
    n = 0;
    while (!(ifa.busy && !ifa.cpu_init) && n < 20) begin tick(); n++; end
    chk("step_paused", dut_a_out(), pk(0, 0, 1, 0, 0, 0));
    en_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        t_step = (c < ((k == 1) ? 3 : 1));
        tick();
        if (ifa.cpu_en) en_cnt++;
      end
    end
    t_step = 0;
    for (int c = 0; c < 3; c++) begin tick(); if (ifa.cpu_en) en_cnt++; end
    chk("step_en_pulses", 32'(en_cnt), 3);
    chk("step_final", dut_a_out(), pk(0, 0, 1, 0, 0, 3));

    // ---------------- timeout and restart (TIMEOUT=20 instance) ----------------
    do_reset();
    t_start = 1; tick(); t_start = 0;
    en_cnt = 0; n = 0;
    while (!ifb.done && n < 100) begin
      if (ifb.cpu_en && !ifb.cpu_init) en_cnt++;
      tick(); n++;
    end
    chk("timeout_en_cycles", 32'(en_cnt), 20);
    chk("timeout_result",
        pk(ifb.cpu_init, ifb.cpu_en, ifb.busy, ifb.done, ifb.timeout, ifb.cycles),
        pk(0, 0, 0, 1, 1, 20));
    t_start = 1; tick(); t_start = 0;
    chk("restart_reset1",
        pk(ifb.cpu_init, ifb.cpu_en, ifb.busy, ifb.done, ifb.timeout, ifb.cycles),
        pk(1, 1, 1, 0, 0, 0));
    tick();
    chk("restart_reset2", 32'(ifb.cpu_init), 1);
    tick();
    chk("restart_run", pk(ifb.cpu_init, ifb.cpu_en, ifb.busy, ifb.done, ifb.timeout, ifb.cycles),
        pk(0, 1, 1, 0, 0, 0));

    // ---------------- randomized run vs reference model ----------------
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      t_start = ($urandom_range(0, 11) == 0);
      t_stop  = ($urandom_range(0, 49) == 0);
      t_step  = ($urandom_range(0, 2) == 0);
      t_halt  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) t_mode = ~t_mode;
      tick();
      chk($sformatf("random[%0d]", i), dut_a_out(), model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller that sequences the single-cycle CPU core: holds it in reset, releases it on a start command, runs it freely or one instruction at a time, and stops it on a halt instruction, an abort or a cycle-budget timeout. It sits between the testbench/host and the CPU top. It drives the CPU's `init` input and a clock enable that gates every state-holding element of the CPU (PC, register file, data-memory writes). It observes the decoder's `halt` output.

## Interface
- `CNT_W`, 16: width of the executed-cycle counter.
- `INIT_CYCLES`, 2: number of cycles `cpu_init` is held during the RESET state; must be ≥ 1.
- `TIMEOUT`, 1000: cycle budget; must satisfy 1 ≤ TIMEOUT ≤ 2^CNT_W − 1.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `init_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a new program run.
- `stop`  in  1  one-cycle pulse; aborts the run and returns to IDLE.
- `mode_step`  in  1  level; 1 = single-step mode, 0 = free run.
- `step`  in  1  one-cycle pulse; executes one instruction while paused.
- `halt`  in  1  from the instruction decoder; the current instruction is a halt.
- `cpu_init`  out  1  drives the CPU's `init` (PC to 0).
- `cpu_en`  out  1  CPU clock enable; the CPU commits state only when this is 1.
- `busy`  out  1  a run is in progress (RESET, RUN, PAUSE or STEP).
- `done`  out  1  the run has ended by halt or timeout.
- `timeout`  out  1  the run ended because the cycle budget was exhausted.
- `cycles`  out  CNT_W  count of executed cycles in the current or last run.

## Operation
- States: IDLE, RESET, RUN, PAUSE, STEP, DONE.
- Outputs are Moore, decoded from the state register:
  - IDLE: `cpu_init`=1, `cpu_en`=0.
  - RESET: `cpu_init`=1, `cpu_en`=1.
  - RUN and STEP: `cpu_init`=0, `cpu_en`=1.
  - PAUSE and DONE: `cpu_init`=0, `cpu_en`=0.
  - `busy`=1 in RESET, RUN, PAUSE and STEP.
  - `done`=1 in DONE.
- IDLE: on `start`, go to RESET, clear `cycles` and clear `timeout`.
- RESET: stay exactly INIT_CYCLES cycles, then go to PAUSE if `mode_step`=1, else to RUN. `cycles` does not count here.
- RUN: `cycles` increments each cycle. On `mode_step`=1, go to PAUSE.
- PAUSE: on `step`, go to STEP. On `mode_step`=0, go to RUN.
- STEP: lasts exactly one cycle, incrementing `cycles`, then returns to PAUSE.
- DONE: `cycles` and `timeout` hold. On `start`, restart (go to RESET, clear `cycles` and `timeout`).
- Exit priority in RUN and STEP, evaluated each cycle: `stop` → IDLE; then `halt` → DONE; then (`cycles` == TIMEOUT−1) → DONE with `timeout`=1; then the normal transition.
  - The halt cycle and the final budget cycle are both counted, so after a timeout `cycles` == TIMEOUT.
- `stop` in any busy state or in DONE returns to IDLE. `cycles` keeps its value.
- `start` while busy is ignored. `step` outside PAUSE is ignored. `halt` outside RUN and STEP is ignored.
- `cycles` never wraps; this is guaranteed by the TIMEOUT bound.

## Timing
- Reset values: state IDLE, `cpu_init`=1, `cpu_en`=0, `busy`=0, `done`=0, `timeout`=0, `cycles`=0.
- `init_n` low at any time, including mid-run, forces the reset values immediately. The CPU is parked in init without a clock enable.
- Start latency: with `start` high at edge N, `cpu_init`=1 and `cpu_en`=1 for edges N+1 … N+INIT_CYCLES. The first instruction fetched from PC 0 executes in the cycle after edge N+INIT_CYCLES.
- Halt: with `halt`=1 and `cpu_en`=1 before edge M, `cpu_en`=0 and `done`=1 after edge M. The halt instruction commits at edge M.
- Single step: one `step` pulse yields exactly one cycle with `cpu_en`=1, regardless of how long `step` is held.
- Simultaneous `stop` and `halt`: `stop` wins; the result is IDLE with `done`=0.

## Structure
- Shared package `cpu_ctrl_pkg` holds the state enum `run_state_t` and the default localparams for `CNT_W` and `TIMEOUT`.
- Single module, no sub-modules. The RESET-length counter may share the `cycles` register width or use its own `$clog2(INIT_CYCLES+1)` counter.

## Test plan
- Reset mid-run: pull `init_n` low during RUN with `cycles`=37 → all outputs return to reset values immediately; `start` then rearms normally.
- Free run: `start` with `mode_step`=0 and `halt` raised on the 10th executed cycle → `cpu_init` high for 2 cycles; then `done`=1, `cycles`=10, `cpu_en`=0, `timeout`=0.
- Timeout: TIMEOUT=20 and `halt` never asserted → `done`=1, `timeout`=1, `cycles`=20; exactly 20 cycles with `cpu_en` high after RESET.
- Single step: `mode_step`=1, then 3 `step` pulses spaced 4 cycles apart, one of them held for 3 cycles → exactly 3 one-cycle `cpu_en` pulses, `cycles`=3, state PAUSE.
- Priority: `stop` and `halt` in the same RUN cycle → IDLE, `done`=0, `cpu_init`=1. A `start` pulse during RUN leaves `cycles` uncleared.
- Restart from DONE: `start` → `cycles` clears to 0, `timeout` clears, RESET repeats for INIT_CYCLES.
